// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The state encoding includes PAR even when SEQGEN_PARITY_EN is left
// undefined, so the encoding stays identical across both builds.
package seqgen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        PAR   = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } seqgen_state_t;

    localparam int SEQGEN_PAT_W_DEF   = 4;
    localparam int SEQGEN_REP_W_DEF   = 4;
    localparam int SEQGEN_GAP_CYC_DEF = 0;

    localparam logic [3:0] SEQGEN_PAT_1001 = 4'b1001;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    // Bit counter uses n = PAT_W; gap counter uses n = GAP_CYC+1.
    function automatic int seqgen_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seqgen_piso.sv
// Loadable parallel-in/serial-out shift register, MSB first.
module seqgen_piso
#(
    parameter int W = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg;

    // Load wins over shift so a reload on the last bit starts the next repetition cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[W-2:0], 1'b0};
        end
    end

    assign msb = sreg[W-1];

endmodule

// File: rtl/sequence_generator_moore.sv
// Serial pattern transmitter (Moore FSM).
// Sends a captured pattern MSB-first on x, repeated reps times (0 means 1),
// with GAP_CYC idle cycles between repetitions.
// Optional macro SEQGEN_PARITY_EN appends an even-parity bit to each repetition.
module sequence_generator_moore
    import seqgen_pkg::*;
#(
    parameter int PAT_W   = SEQGEN_PAT_W_DEF,
    parameter int REP_W   = SEQGEN_REP_W_DEF,
    parameter int GAP_CYC = SEQGEN_GAP_CYC_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             ready,
    output logic             done
);

    localparam int CNT_W  = seqgen_cnt_w(PAT_W);
    localparam int GCNT_W = seqgen_cnt_w(GAP_CYC + 1);

    seqgen_state_t     state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [GCNT_W-1:0] gap_cnt;
    logic [PAT_W-1:0]  pat_q;
    logic              shift_q;
`ifdef SEQGEN_PARITY_EN
    logic              par_q;
`endif

    logic              last_bit;
    logic              more_reps;
    logic              gap_last;
    logic              rep_end;
    logic              active;
    logic              piso_load;
    logic              piso_shift;
    logic [PAT_W-1:0]  piso_din;
    logic              piso_msb;

    // Decode end-of-bit, end-of-repetition and shift-register controls from the current state.
    always_comb begin
        last_bit  = (bit_cnt == CNT_W'(PAT_W - 1));
        more_reps = (rep_cnt != REP_W'(1));
        gap_last  = (gap_cnt == GCNT_W'(GAP_CYC - 1));
`ifdef SEQGEN_PARITY_EN
        rep_end   = (state == PAR);
`else
        rep_end   = (state == SHIFT) && last_bit;
`endif
        active    = (state == SHIFT) || (state == PAR) || (state == GAP);
        piso_load = ((state == IDLE) && start && !abort)
                 || (!abort && rep_end && more_reps && (GAP_CYC == 0))
                 || (!abort && (state == GAP) && gap_last);
        piso_shift = (state == SHIFT) && !last_bit && !abort;
        piso_din   = (state == IDLE) ? pattern : pat_q;
    end

    seqgen_piso #(
        .W (PAT_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .msb   (piso_msb)
    );

    // FSM with counters and registered status outputs; abort outranks everything but reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            pat_q   <= '0;
            shift_q <= 1'b0;
`ifdef SEQGEN_PARITY_EN
            par_q   <= 1'b0;
`endif
            x_valid <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else if (active && abort) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shift_q <= 1'b0;
`ifdef SEQGEN_PARITY_EN
            par_q   <= 1'b0;
`endif
            x_valid <= 1'b0;
            ready   <= 1'b1;
        end else if (rep_end) begin
            shift_q <= 1'b0;
`ifdef SEQGEN_PARITY_EN
            par_q   <= 1'b0;
`endif
            bit_cnt <= '0;
            rep_cnt <= rep_cnt - REP_W'(1);
            if (more_reps) begin
                if (GAP_CYC > 0) begin
                    state   <= GAP;
                    gap_cnt <= '0;
                    x_valid <= 1'b0;
                end else begin
                    state   <= SHIFT;
                    shift_q <= 1'b1;
                    x_valid <= 1'b1;
                end
            end else begin
                state   <= DONE;
                x_valid <= 1'b0;
                done    <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= SHIFT;
                        pat_q   <= pattern;
                        rep_cnt <= (reps == '0) ? REP_W'(1) : reps;
                        bit_cnt <= '0;
                        shift_q <= 1'b1;
                        x_valid <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                SHIFT: begin
`ifdef SEQGEN_PARITY_EN
                    if (last_bit) begin
                        state   <= PAR;
                        shift_q <= 1'b0;
                        par_q   <= ^pat_q;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
`else
                    bit_cnt <= bit_cnt + CNT_W'(1);
`endif
                end
                GAP: begin
                    if (gap_last) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shift_q <= 1'b1;
                        x_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GCNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQGEN_PARITY_EN
    assign x = (shift_q & piso_msb) | par_q;
`else
    assign x = shift_q & piso_msb;
`endif

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Directed self-checking bench for sequence_generator_moore.
// Two instances: d0 back-to-back (GAP_CYC=0) and d2 with two idle cycles (GAP_CYC=2).
// Honours SEQGEN_PARITY_EN when the build defines it.
module tb_sequence_generator_moore;

    logic       clk;
    logic       rst;
    logic       start0;
    logic       start2;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic       abort;
    logic       x0, xv0, rdy0, dn0;
    logic       x2, xv2, rdy2, dn2;

    int checks;
    int errors;

    sequence_generator_moore #(
        .PAT_W   (4),
        .REP_W   (4),
        .GAP_CYC (0)
    ) dut0 (
        .clk     (clk),
        .rst     (rst),
        .start   (start0),
        .pattern (pattern),
        .reps    (reps),
        .abort   (abort),
        .x       (x0),
        .x_valid (xv0),
        .ready   (rdy0),
        .done    (dn0)
    );

    sequence_generator_moore #(
        .PAT_W   (4),
        .REP_W   (4),
        .GAP_CYC (2)
    ) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .pattern (pattern),
        .reps    (reps),
        .abort   (abort),
        .x       (x2),
        .x_valid (xv2),
        .ready   (rdy2),
        .done    (dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic st, input logic [3:0] pat,
                                 input logic [3:0] rp, input logic ab);
        if (sel == 0) start0 = st;
        else          start2 = st;
        pattern = pat;
        reps    = rp;
        abort   = ab;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input int sel, input string tag, input logic ex, input logic exv,
                              input logic erdy, input logic edn);
        logic ax, av, ar, ad;
        if (sel == 0) begin
            ax = x0; av = xv0; ar = rdy0; ad = dn0;
        end else begin
            ax = x2; av = xv2; ar = rdy2; ad = dn2;
        end
        checkOutput({tag, ".x"},       ax, ex);
        checkOutput({tag, ".x_valid"}, av, exv);
        checkOutput({tag, ".ready"},   ar, erdy);
        checkOutput({tag, ".done"},    ad, edn);
    endtask

    // Starts one transmission and checks every cycle up to two cycles after done.
    // Pattern/reps are scrambled right after capture; optional start pulses land mid-burst or in DONE.
    task automatic runBurst(input int sel, input string tag, input logic [3:0] pat,
                            input logic [3:0] rp, input int gap,
                            input bit pulse_mid, input bit pulse_done);
        int n;
        int cyc;
        n = (rp == 4'd0) ? 1 : int'(rp);
        applyStimulus(sel, 1'b1, pat, rp, 1'b0);
        tick();
        cyc = 0;
        for (int r = 0; r < n; r++) begin
            for (int i = 3; i >= 0; i--) begin
                checkCycle(sel, $sformatf("%s.r%0d.b%0d", tag, r, i), pat[i], 1'b1, 1'b0, 1'b0);
                applyStimulus(sel, pulse_mid && (cyc == 1), ~pat, ~rp, 1'b0);
                tick();
                cyc++;
            end
`ifdef SEQGEN_PARITY_EN
            checkCycle(sel, $sformatf("%s.r%0d.par", tag, r), ^pat, 1'b1, 1'b0, 1'b0);
            applyStimulus(sel, 1'b0, ~pat, ~rp, 1'b0);
            tick();
`endif
            if (r < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    checkCycle(sel, $sformatf("%s.r%0d.gap%0d", tag, r, g), 1'b0, 1'b0, 1'b0, 1'b0);
                    tick();
                end
            end
        end
        checkCycle(sel, {tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(sel, pulse_done, ~pat, ~rp, 1'b0);
        tick();
        checkCycle(sel, {tag, ".idle"}, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(sel, 1'b0, pat, rp, 1'b0);
        tick();
        checkCycle(sel, {tag, ".idle2"}, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        start0  = 1'b0;
        start2  = 1'b0;
        pattern = 4'd0;
        reps    = 4'd0;
        abort   = 1'b0;

        #12;
        checkCycle(0, "reset.d0", 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle(2, "reset.d2", 1'b0, 1'b0, 1'b1, 1'b0);
        #8 rst = 1'b1;
        tick();

        $display("[TB] abort while idle");
        applyStimulus(0, 1'b0, seqgen_pkg::SEQGEN_PAT_1001, 4'd1, 1'b1);
        tick();
        checkCycle(0, "idleAbort", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, seqgen_pkg::SEQGEN_PAT_1001, 4'd1, 1'b0);
        tick();

        $display("[TB] single burst, reps=1");
        runBurst(0, "single", seqgen_pkg::SEQGEN_PAT_1001, 4'd1, 0, 1'b0, 1'b0);

        $display("[TB] gapped burst, reps=3, gap=2");
        runBurst(2, "gapped", seqgen_pkg::SEQGEN_PAT_1001, 4'd3, 2, 1'b0, 1'b0);

        $display("[TB] reps=0 with ignored start pulses");
        runBurst(0, "repsZero", seqgen_pkg::SEQGEN_PAT_1001, 4'd0, 0, 1'b1, 1'b1);

        $display("[TB] back-to-back reps=2");
        runBurst(0, "b2b", 4'b1011, 4'd2, 0, 1'b0, 1'b0);

        $display("[TB] saturated reps");
        runBurst(0, "saturated", 4'b0110, 4'hF, 0, 1'b0, 1'b0);

        $display("[TB] abort on second bit");
        applyStimulus(0, 1'b1, seqgen_pkg::SEQGEN_PAT_1001, 4'd3, 1'b0);
        tick();
        checkCycle(0, "abort.b3", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, seqgen_pkg::SEQGEN_PAT_1001, 4'd3, 1'b0);
        tick();
        checkCycle(0, "abort.b2", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, seqgen_pkg::SEQGEN_PAT_1001, 4'd3, 1'b1);
        tick();
        checkCycle(0, "abort.idle", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, seqgen_pkg::SEQGEN_PAT_1001, 4'd3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkCycle(0, $sformatf("abort.quiet%0d", k), 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] asynchronous reset mid-burst");
        applyStimulus(2, 1'b1, seqgen_pkg::SEQGEN_PAT_1001, 4'd2, 1'b0);
        tick();
        applyStimulus(2, 1'b0, seqgen_pkg::SEQGEN_PAT_1001, 4'd2, 1'b0);
        checkCycle(2, "preReset", 1'b1, 1'b1, 1'b0, 1'b0);
        #3 rst = 1'b0;
        #1;
        checkCycle(2, "asyncReset", 1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        tick();
        checkCycle(2, "postReset", 1'b0, 1'b0, 1'b1, 1'b0);
        runBurst(2, "afterReset", 4'b1011, 4'd2, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator_moore.md
Name: sequence_generator_moore

Overview:
- Serial pattern transmitter: the sending end of the serial bit-stream link consumed by the team's sequence detectors.
- Loads a PAT_W-bit pattern and serializes it MSB-first onto x, repeated a programmable number of times with optional idle gaps between repetitions.
- Moore FSM; all outputs are registered and are functions of state only.
- Drives detector stimulus in loopback benches and on-chip self-test.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- REP_W, 4, width of the repeat-count input.
- GAP_CYC, 0, idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to transmit; sampled only when ready=1.
- pattern  in  PAT_W  pattern to send; captured on accepted start.
- reps  in  REP_W  repetition count; captured on accepted start; 0 treated as 1.
- abort  in  1  synchronous cancel of the current transmission.
- x  out  1  serial data out.
- x_valid  out  1  high while x carries a pattern or parity bit.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, x=0, x_valid=0, ready=1, done=0; shift register, bit counter, repeat counter and gap counter cleared. Reset mid-transmission cuts the stream immediately.
- States: IDLE, SHIFT, PAR (only with PARITY_EN), GAP, DONE.
- IDLE:
  - ready=1, x=0, x_valid=0.
  - start=1 at edge T: capture pattern and reps (0 -> 1), go to SHIFT.
  - Latency 1: first bit pattern[PAT_W-1] is on x, with x_valid=1, in cycle T+1.
- SHIFT:
  - x = shift-register MSB; shift left each cycle; bit counter counts PAT_W cycles.
  - After the last bit:
    - PAR if PARITY_EN is defined;
    - else if repetitions remain: GAP when GAP_CYC>0, otherwise reload the captured pattern and stay in SHIFT (no bubble);
    - else DONE.
- GAP: x=0, x_valid=0 for exactly GAP_CYC cycles, then reload the pattern and enter SHIFT.
- DONE: done=1, ready=0, x_valid=0 for exactly one cycle, then IDLE.
- start while ready=0 (including in DONE) is ignored.
- pattern/reps changes after capture have no effect.
- abort=1 in SHIFT/PAR/GAP: next state IDLE, x_valid=0, no done pulse. abort in IDLE or DONE has no effect.
- abort has priority over start when both are high.
- Repeat counter decrements at the end of each repetition; a saturated reps (all ones) sends 2^REP_W-1 repetitions.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined: PAR state appends one even-parity bit (XOR of the captured pattern) after each repetition, with x_valid=1. Each repetition is PAT_W+1 cycles.
- Undefined: PAR state and parity logic are absent; each repetition is PAT_W cycles.

Decomposition:
- Package seqgen_pkg holds:
  - typedef seqgen_state_t for the state encoding (IDLE, SHIFT, PAR, GAP, DONE);
  - localparam widths for the bit counter ($clog2(PAT_W)) and gap counter ($clog2(GAP_CYC+1));
  - default pattern constant SEQGEN_PAT_1001 = 4'b1001.
- One natural sub-module: seqgen_piso, a loadable parallel-in/serial-out shift register with load/shift enables and MSB output. The FSM and counters stay in the top module.

Test Plan:
- Async reset: rst=0 asserted mid-SHIFT, between clock edges -> x=0, x_valid=0, ready=1 immediately; after release, start works normally.
- pattern=4'b1001, reps=1, GAP_CYC=0, start at edge T -> x=1,0,0,1 with x_valid=1 in T+1..T+4; done=1 in T+5; ready=1 from T+6.
- pattern=1001, reps=3, GAP_CYC=2 -> bursts 1001 / 2 idle / 1001 / 2 idle / 1001 (16 cycles), then done. Looped into sequence_detector_1001_moore, y asserts exactly 3 times.
- reps=0 -> identical to reps=1. start pulsed during SHIFT -> ignored, no second burst.
- abort=1 during the second bit of 1001 -> next cycle IDLE, x_valid=0, ready=1, done never pulses.
- SEQGEN_PARITY_EN defined: pattern 1001 -> x=1,0,0,1,0; pattern 1011 -> x=1,0,1,1,1; done one cycle after the parity bit.
